// File: rtl/stack_fifo_ctrl.sv
// Buffer controller with integrated storage that returns words in LIFO (MODE=0) or FIFO (MODE=1) order.
// It provides occupancy, full/empty status, sticky overflow/underflow flags and a registered pop handshake.
module stack_fifo_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  parameter  int MODE  = 0,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [AW-1:0]    ptr,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam bit            IS_FIFO  = (MODE == 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_bypass;
  logic             w_inc;
  logic             w_dec;
  logic             w_adv_head;
  logic             w_adv_tail;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  // Only meaningful when the stack is non-empty; DEPTH-1 when full.
  assign w_top   = AW'(r_count - CW'(1));

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_wr_en    = 1'b0;
    w_rd_en    = 1'b0;
    w_bypass   = 1'b0;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    w_adv_head = 1'b0;
    w_adv_tail = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    w_wr_addr  = IS_FIFO ? r_tail : r_count[AW-1:0];
    w_rd_addr  = IS_FIFO ? r_head : w_top;

    case ({push, pop})
      2'b10: begin
        if (!w_full) begin
          w_wr_en    = 1'b1;
          w_inc      = 1'b1;
          w_adv_tail = IS_FIFO;
        end else begin
          w_set_ovf  = 1'b1;
        end
      end
      2'b01: begin
        if (!w_empty) begin
          w_rd_en    = 1'b1;
          w_dec      = 1'b1;
          w_adv_head = IS_FIFO;
        end else begin
          w_set_unf  = 1'b1;
        end
      end
      2'b11: begin
        // Swap: read and write in the same edge; the read sees the pre-write contents.
        if (!w_empty) begin
          w_rd_en    = 1'b1;
          w_wr_en    = 1'b1;
          w_adv_head = IS_FIFO;
          w_adv_tail = IS_FIFO;
          if (!IS_FIFO) begin
            w_wr_addr = w_top;
          end
        end else begin
          w_bypass   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_inc) begin
        r_count <= r_count + CW'(1);
      end else if (w_dec) begin
        r_count <= r_count - CW'(1);
      end
      if (w_adv_head) begin
        r_head <= r_head + AW'(1);
      end
      if (w_adv_tail) begin
        r_tail <= r_tail + AW'(1);
      end
      r_dout_valid <= w_rd_en | w_bypass;
      if (w_rd_en) begin
        r_dout <= r_mem[w_rd_addr];
      end else if (w_bypass) begin
        r_dout <= din;
      end
      // A new error in the same cycle as clr_err wins.
      r_overflow  <= w_set_ovf | (r_overflow  & ~clr_err);
      r_underflow <= w_set_unf | (r_underflow & ~clr_err);
    end
  end

  // NOTE: storage is deliberately not reset; its contents are unreachable until written.
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      r_mem[w_wr_addr] <= din;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign ptr        = IS_FIFO ? r_tail : r_count[AW-1:0];
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_stack_fifo_ctrl.sv
// Bench for stack_fifo_ctrl: a LIFO and a FIFO instance (DEPTH=4, WIDTH=8) with scoreboarded pop data.
// Status outputs are checked directly after each edge; popped data is checked by negedge monitors.
module tb_stack_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;

  logic       l_push, l_pop, l_clr;
  logic [7:0] l_din;
  logic [7:0] l_dout;
  logic       l_dout_valid, l_empty, l_full, l_ovf, l_unf;
  logic [1:0] l_ptr;
  logic [2:0] l_count;

  logic       f_push, f_pop, f_clr;
  logic [7:0] f_din;
  logic [7:0] f_dout;
  logic       f_dout_valid, f_empty, f_full, f_ovf, f_unf;
  logic [1:0] f_ptr;
  logic [2:0] f_count;

  logic [7:0] exp_l[$];
  logic [7:0] exp_f[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  stack_fifo_ctrl #(.WIDTH(8), .DEPTH(4), .MODE(0)) u_lifo (
    .clk(clk), .reset(reset), .push(l_push), .pop(l_pop), .din(l_din), .clr_err(l_clr),
    .dout(l_dout), .dout_valid(l_dout_valid), .ptr(l_ptr), .count(l_count),
    .empty(l_empty), .full(l_full), .overflow(l_ovf), .underflow(l_unf)
  );

  stack_fifo_ctrl #(.WIDTH(8), .DEPTH(4), .MODE(1)) u_fifo (
    .clk(clk), .reset(reset), .push(f_push), .pop(f_pop), .din(f_din), .clr_err(f_clr),
    .dout(f_dout), .dout_valid(f_dout_valid), .ptr(f_ptr), .count(f_count),
    .empty(f_empty), .full(f_full), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitors: every dout_valid pulse must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (l_dout_valid === 1'b1) begin
      if (exp_l.size() == 0) check("lifo_spurious_valid", {24'd0, l_dout}, 32'hFFFF_FFFF);
      else                   check("lifo_dout", {24'd0, l_dout}, {24'd0, exp_l.pop_front()});
    end
    if (f_dout_valid === 1'b1) begin
      if (exp_f.size() == 0) check("fifo_spurious_valid", {24'd0, f_dout}, 32'hFFFF_FFFF);
      else                   check("fifo_dout", {24'd0, f_dout}, {24'd0, exp_f.pop_front()});
    end
  end

  task automatic drive_l(input logic p, input logic q, input logic [7:0] d, input logic c);
    l_push = p; l_pop = q; l_din = d; l_clr = c;
    @(posedge clk); #1;
    l_push = 1'b0; l_pop = 1'b0; l_clr = 1'b0;
  endtask

  task automatic drive_f(input logic p, input logic q, input logic [7:0] d, input logic c);
    f_push = p; f_pop = q; f_din = d; f_clr = c;
    @(posedge clk); #1;
    f_push = 1'b0; f_pop = 1'b0; f_clr = 1'b0;
  endtask

  task automatic pop_l(input logic [7:0] e);
    exp_l.push_back(e);
    drive_l(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic pop_f(input logic [7:0] e);
    exp_f.push_back(e);
    drive_f(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic push_f_ptr(input logic [7:0] d, input logic [1:0] p);
    drive_f(1'b1, 1'b0, d, 1'b0);
    check("fifo_ptr", {30'd0, f_ptr}, {30'd0, p});
  endtask

  initial begin
    logic [7:0] fill [4];
    logic [7:0] wrap_in [6];
    fill    = '{8'h11, 8'h22, 8'h33, 8'h44};
    wrap_in = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    l_push = 0; l_pop = 0; l_clr = 0; l_din = 0;
    f_push = 0; f_pop = 0; f_clr = 0; f_din = 0;
    reset = 1'b1;
    #12;
    check("rst_count", {29'd0, l_count}, 0);
    check("rst_empty", {31'd0, l_empty}, 1);
    check("rst_full", {31'd0, l_full}, 0);
    check("rst_ptr", {30'd0, l_ptr}, 0);
    check("rst_dout", {24'd0, l_dout}, 0);
    check("rst_valid", {31'd0, l_dout_valid}, 0);
    check("rst_ovf", {31'd0, l_ovf}, 0);
    check("rst_unf", {31'd0, l_unf}, 0);
    check("rst_fifo_empty", {31'd0, f_empty}, 1);
    reset = 1'b0;

    // LIFO fill
    for (int i = 0; i < 4; i++) begin
      drive_l(1'b1, 1'b0, fill[i], 1'b0);
      check("lifo_fill_count", {29'd0, l_count}, i + 1);
    end
    check("lifo_full", {31'd0, l_full}, 1);
    check("lifo_full_ptr", {30'd0, l_ptr}, 0);
    check("lifo_full_empty", {31'd0, l_empty}, 0);

    // Overflow, clear-vs-set priority, clear
    drive_l(1'b1, 1'b0, 8'h55, 1'b0);
    check("ovf_count", {29'd0, l_count}, 4);
    check("ovf_set", {31'd0, l_ovf}, 1);
    drive_l(1'b1, 1'b0, 8'h66, 1'b1);
    check("ovf_set_dominant", {31'd0, l_ovf}, 1);
    drive_l(1'b0, 1'b0, 8'h00, 1'b1);
    check("ovf_cleared", {31'd0, l_ovf}, 0);

    // LIFO drain
    for (int i = 3; i >= 0; i--) pop_l(fill[i]);
    check("lifo_drain_empty", {31'd0, l_empty}, 1);
    check("lifo_drain_count", {29'd0, l_count}, 0);

    // Underflow
    drive_l(1'b0, 1'b1, 8'h00, 1'b0);
    check("unf_set", {31'd0, l_unf}, 1);
    check("unf_dout_hold", {24'd0, l_dout}, 32'h11);
    check("unf_count", {29'd0, l_count}, 0);
    drive_l(1'b0, 1'b0, 8'h00, 1'b1);
    check("unf_cleared", {31'd0, l_unf}, 0);
    check("ovf_still_clear", {31'd0, l_ovf}, 0);

    // LIFO swap
    drive_l(1'b1, 1'b0, 8'hA0, 1'b0);
    drive_l(1'b1, 1'b0, 8'hA1, 1'b0);
    exp_l.push_back(8'hA1);
    drive_l(1'b1, 1'b1, 8'hB0, 1'b0);
    check("swap_count", {29'd0, l_count}, 2);
    check("swap_no_ovf", {31'd0, l_ovf}, 0);
    pop_l(8'hB0);
    pop_l(8'hA0);

    // Empty bypass
    exp_l.push_back(8'hC5);
    drive_l(1'b1, 1'b1, 8'hC5, 1'b0);
    check("bypass_count", {29'd0, l_count}, 0);
    check("bypass_ovf", {31'd0, l_ovf}, 0);
    check("bypass_unf", {31'd0, l_unf}, 0);
    check("bypass_dout", {24'd0, l_dout}, 32'hC5);

    // Mid-burst asynchronous reset with push held through it
    drive_l(1'b1, 1'b0, 8'h01, 1'b0);
    drive_l(1'b1, 1'b0, 8'h02, 1'b0);
    l_push = 1'b1; l_din = 8'h03;
    @(posedge clk); #1;
    check("burst_count", {29'd0, l_count}, 3);
    #2 reset = 1'b1;
    #1;
    check("midrst_count", {29'd0, l_count}, 0);
    check("midrst_empty", {31'd0, l_empty}, 1);
    check("midrst_ptr", {30'd0, l_ptr}, 0);
    check("midrst_dout", {24'd0, l_dout}, 0);
    @(posedge clk); #1;
    check("rst_push_ignored", {29'd0, l_count}, 0);
    l_push = 1'b0;
    #2 reset = 1'b0;
    drive_l(1'b1, 1'b0, 8'h77, 1'b0);
    check("post_rst_count", {29'd0, l_count}, 1);
    pop_l(8'h77);

    // FIFO wrap: head and tail both pass index 3
    push_f_ptr(wrap_in[0], 2'd1);
    push_f_ptr(wrap_in[1], 2'd2);
    push_f_ptr(wrap_in[2], 2'd3);
    pop_f(wrap_in[0]);
    push_f_ptr(wrap_in[3], 2'd0);
    pop_f(wrap_in[1]);
    push_f_ptr(wrap_in[4], 2'd1);
    push_f_ptr(wrap_in[5], 2'd2);
    for (int i = 2; i < 6; i++) pop_f(wrap_in[i]);
    check("fifo_wrap_empty", {31'd0, f_empty}, 1);

    // Full FIFO swap
    for (int i = 0; i < 4; i++) drive_f(1'b1, 1'b0, 8'hF0 + 8'(i), 1'b0);
    check("fifo_full", {31'd0, f_full}, 1);
    exp_f.push_back(8'hF0);
    drive_f(1'b1, 1'b1, 8'hF4, 1'b0);
    check("fifo_swap_count", {29'd0, f_count}, 4);
    check("fifo_swap_no_ovf", {31'd0, f_ovf}, 0);
    for (int i = 1; i < 5; i++) pop_f(8'hF0 + 8'(i));

    // FIFO bypass
    exp_f.push_back(8'h5A);
    drive_f(1'b1, 1'b1, 8'h5A, 1'b0);
    check("fifo_bypass_count", {29'd0, f_count}, 0);
    check("fifo_bypass_unf", {31'd0, f_unf}, 0);

    repeat (3) @(posedge clk);
    #1;
    check("lifo_outstanding", exp_l.size(), 0);
    check("fifo_outstanding", exp_f.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_fifo_ctrl.md
# stack_fifo_ctrl

Parametrised buffer controller with integrated storage, the successor to the 4-bit push/pop pointer controller. It tracks occupancy with push/pop strobes, stores WIDTH-bit words and returns them in LIFO or FIFO order, selected by a parameter. It adds full/empty status, sticky overflow/underflow error flags and a registered read-data handshake. It sits between a producer issuing `push` and a consumer issuing `pop`, such as a call-return address stack or a command queue.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2; AW = $clog2(DEPTH), CW = AW+1
- MODE, 0, 0 = LIFO (stack), 1 = FIFO (queue)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- push  in  1  write request; `din` is sampled on the same edge
- pop  in  1  read request
- din  in  WIDTH  write data
- clr_err  in  1  synchronous clear of `overflow` and `underflow`
- dout  out  WIDTH  registered read data
- dout_valid  out  1  high for exactly one cycle when `dout` holds newly popped data
- ptr  out  AW  current write position: LIFO = stack pointer (count mod DEPTH), FIFO = tail pointer
- count  out  CW  occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was dropped

## Operation
- Reset, asynchronous and taking effect immediately: count=0, ptr=0, head/tail=0, dout=0, dout_valid=0, empty=1, full=0, overflow=0, underflow=0. Memory contents are not reset and are don't-care.
- Classify each cycle by {push, pop} and the current count:
  - Idle (0,0): no change; dout holds; dout_valid=0.
  - Push only, not full: mem[wr]←din; count+1; ptr advances.
  - Push only, full: no write; count unchanged; overflow←1.
  - Pop only, not empty: dout←oldest entry (FIFO) or top entry (LIFO, mem[count-1]); dout_valid=1 next cycle; count-1.
  - Pop only, empty: dout holds; dout_valid=0; underflow←1.
  - Both, not empty (including full): one atomic swap with count unchanged and no error flag set.
    - LIFO: dout←old top, then top←din.
    - FIFO: dout←head entry, din written at tail, head and tail both advance.
    - dout_valid=1.
  - Both, empty: bypass. dout←din, dout_valid=1, count stays 0, no flag set, memory not written.
- FIFO pointers wrap from DEPTH-1 to 0. count disambiguates full from empty; no pointer-equality tricks.
- LIFO: ptr = count[AW-1:0]. When full, ptr reads 0 because of the wrap.
- Error flags:
  - Set-dominant over `clr_err`: if a clear and a new error occur in the same cycle, the flag reads 1 afterwards.
  - Cleared only by reset or by `clr_err`.
- empty and full are decoded combinationally from the count register, so they are glitch-free with respect to the count.

## Timing
- All outputs except empty and full are registered.
- Pop latency: request on edge N → dout and dout_valid valid after edge N, for cycle N+1. dout_valid deasserts the following cycle unless another pop succeeds.
- Push visibility: a word pushed on edge N can be popped by a pop on edge N+1. FIFO with count=0 → the same-cycle case uses the bypass rule instead.
- Back-to-back push or pop every cycle is supported at full rate.
- Reset asserted mid-operation:
  - All outputs return to reset values within the same cycle.
  - A push or pop coincident with reset assertion is discarded.
  - Operation resumes on the first rising edge after deassertion.

## Test plan
- Reset values: assert reset at an arbitrary time, including mid-burst → count=0, empty=1, full=0, ptr=0, dout=0, dout_valid=0, flags=0; a push held during reset does not change count.
- LIFO fill/drain (MODE=0, DEPTH=4, WIDTH=8):
  - Push 0x11, 0x22, 0x33, 0x44 → full=1, count=4, ptr=0.
  - 4 pops → dout 0x44, 0x33, 0x22, 0x11, each with a one-cycle dout_valid pulse; empty=1 after the last pop.
- Overflow/underflow:
  - 5th push when full → count stays 4, overflow=1.
  - Pop when empty → underflow=1, dout unchanged.
  - clr_err in the same cycle as a new overflow → overflow stays 1.
  - clr_err alone → both flags 0.
- Simultaneous push+pop:
  - LIFO holding 0xA0, 0xA1 with din=0xB0 → dout=0xA1, count=2; next pop → 0xB0.
  - Empty, din=0xC5 → dout=0xC5, count=0, no flags.
  - Full FIFO → no overflow, count=DEPTH.
- FIFO wrap (MODE=1, DEPTH=4): push 6 words and pop 6 words, interleaved so that head and tail each wrap past 3 → output order equals input order; ptr sequence 1,2,3,0,1,2.
